id_hazard_fwd_unit: RTL
=======================

// Module: id_hazard_fwd_unit
// PURPOSE
//  Parametrised ID-stage front end: IF->ID pipeline register, an instruction hold buffer
//  covering stalls, N-source operand forwarding, and load-use interlock (stallreq).
//  Sits between IF/inst SRAM and the ID decoder; the decoder consumes id_inst/id_pc/rdata*.
//  Successor to the fixed 3-source ID forwarding: source count and load latency are generic.
// PARAMETERS
//  DW        32  operand data width
//  AW        5   register address width
//  NUM_FWD   3   forwarding sources; index 0 = youngest (EX), highest priority
//  LOAD_LAT  2   sources with index < LOAD_LAT cannot forward load data (1..NUM_FWD)
//  STALL_W   6   width of the stall bus
// PORTS
//  clk              in   1               clock, all state on rising edge
//  rst              in   1               synchronous reset, active-low
//  stall            in   STALL_W         stall[1]=IF->ID hold, stall[2]=ID hold
//  if_ce            in   1               IF valid
//  if_pc            in   32              IF pc
//  inst_sram_rdata  in   32              instruction SRAM read data
//  rs_addr, rt_addr in   AW              source register addresses (from decoder)
//  rs_ren, rt_ren   in   1               source actually read by this instruction
//  rf_rdata1/2      in   DW              regfile read data for rs/rt
//  fwd_bus          in   NUM_FWD*(2+AW+DW) per source i: {is_load, we, waddr, wdata}, i=0 in LSBs
//  id_valid         out  1               ID holds a live instruction
//  id_pc            out  32              pc of ID instruction
//  id_inst          out  32              instruction word (0 when !id_valid)
//  rdata1, rdata2   out  DW              forwarded rs/rt operands
//  stallreq         out  1               load-use interlock request
//  perf_lu_cnt      out  32              load-use stall cycles (ID_PERF_CNT_EN only)
// BEHAVIOUR
//  Pipeline reg {valid,pc}: rst=0 -> 0. stall[1]&!stall[2] -> bubble {0,0}.
//   !stall[1] -> {if_ce,if_pc}. Otherwise hold. Latency IF->ID: 1 cycle.
//  Hold buffer: SRAM data changes during stalls, so on first cycle with stall[2]=1
//   and hold_vld=0: hold_r<=inst_sram_rdata, hold_vld<=1. While stall[2]=1 hold_r frozen.
//   stall[2]=0 -> hold_vld<=0. id_inst = !id_valid ? 0 : hold_vld ? hold_r : inst_sram_rdata.
//   rst=0 -> hold_r=0, hold_vld=0. Bubble insertion also clears hold_vld.
//  Forwarding (combinational), per operand addr A: if A==0 -> rf data (no forward).
//   Else first i ascending with we_i & waddr_i==A supplies wdata_i; none -> rf_rdata.
//   Multiple matches: lowest index wins. we_i=0 entries ignored regardless of waddr.
//  Load-use: hazard if any i<LOAD_LAT has is_load_i & we_i & waddr_i==A & A!=0 & ren
//   for rs or rt, and it is the winning (lowest-index) match for that operand.
//   stallreq = hazard & id_valid (combinational, same cycle). Operand value during
//   stallreq is don't-care; it is re-evaluated each stalled cycle.
//  Reset mid-stall: all state cleared next edge; stallreq falls as id_valid=0.
// CONFIGURATION
//  ID_PERF_CNT_EN defined: 32-bit perf_lu_cnt, +1 each cycle stallreq=1, saturates at
//   32'hFFFF_FFFF, reset 0, port present. Undefined: port and counter absent;
//   all other behaviour bit-identical.
// TESTING
//  1 Reset: rst=0 2 cycles -> id_valid=0, id_pc=0, id_inst=0, stallreq=0, perf_lu_cnt=0.
//  2 Priority: src0 {we=1,waddr=5,wdata=AA}, src2 {we=1,waddr=5,wdata=CC}, rs=5 -> rdata1=AA;
//    src0 we=0 -> rdata1=CC; rs=0 with match on waddr 0 -> rdata1=rf_rdata1.
//  3 Load-use: src0 {is_load=1,we=1,waddr=8}, rt=8,rt_ren=1 -> stallreq=1; rt_ren=0 -> 0;
//    same load at index LOAD_LAT(2) -> stallreq=0, rdata2=wdata_2.
//  4 Hold: inst 0x3C01_1234 in ID, stall[2]=1 3 cycles with SRAM data changing ->
//    id_inst stays 0x3C01_1234; stall released -> follows SRAM next cycle.
//  5 Bubble: stall[1]=1,stall[2]=0 -> next cycle id_valid=0,id_inst=0; stall[1]=stall[2]=1 -> hold.
//  6 Perf (EN): 4 load-use cycles -> perf_lu_cnt=4; preload 32'hFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage front end: IF->ID register, stall hold buffer, N-source forwarding, load-use interlock.
// Optional load-use stall counter (perf_lu_cnt) when ID_PERF_CNT_EN is defined.
module id_hazard_fwd_unit #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 2,
  parameter int STALL_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STALL_W-1:0]           stall,
  input  logic                         if_ce,
  input  logic [31:0]                  if_pc,
  input  logic [31:0]                  inst_sram_rdata,
  input  logic [AW-1:0]                rs_addr,
  input  logic [AW-1:0]                rt_addr,
  input  logic                         rs_ren,
  input  logic                         rt_ren,
  input  logic [DW-1:0]                rf_rdata1,
  input  logic [DW-1:0]                rf_rdata2,
  input  logic [NUM_FWD*(2+AW+DW)-1:0] fwd_bus,
  output logic                         id_valid,
  output logic [31:0]                  id_pc,
  output logic [31:0]                  id_inst,
  output logic [DW-1:0]                rdata1,
  output logic [DW-1:0]                rdata2,
  output logic                         stallreq
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_lu_cnt
`endif
);

  localparam int FW = 2 + AW + DW;

  typedef struct packed {
    logic          is_load;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } fwd_src_t;

  fwd_src_t src [NUM_FWD];

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_unpack
    assign src[g] = fwd_bus[g*FW +: FW];
  end

  logic        if_hold;
  logic        id_hold;
  logic        bubble;
  logic [31:0] hold_r;
  logic        hold_vld;
  logic        unused_stall;

  assign if_hold = stall[1];
  assign id_hold = stall[2];
  assign bubble  = if_hold & ~id_hold;

  assign unused_stall = ^{stall[0], stall[STALL_W-1:3]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (bubble) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (!if_hold) begin
      id_valid <= if_ce;
      id_pc    <= if_pc;
    end
  end

  // SRAM output moves on during stalls; capture the word once per stall run
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_r   <= '0;
      hold_vld <= 1'b0;
    end else if (id_hold) begin
      if (!hold_vld) begin
        hold_r   <= inst_sram_rdata;
        hold_vld <= 1'b1;
      end
    end else begin
      hold_vld <= 1'b0;
    end
  end

  always_comb begin
    id_inst = '0;
    if (id_valid)
      id_inst = hold_vld ? hold_r : inst_sram_rdata;
  end

  logic ld1;
  logic ld2;

  // Descending scan so the lowest-index match is applied last
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    ld1    = 1'b0;
    ld2    = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (src[i].we && src[i].waddr == rs_addr && rs_addr != '0) begin
        rdata1 = src[i].wdata;
        ld1    = src[i].is_load && (i < LOAD_LAT);
      end
      if (src[i].we && src[i].waddr == rt_addr && rt_addr != '0) begin
        rdata2 = src[i].wdata;
        ld2    = src[i].is_load && (i < LOAD_LAT);
      end
    end
  end

  assign stallreq = id_valid & ((ld1 & rs_ren) | (ld2 & rt_ren));

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      perf_lu_cnt <= '0;
    else if (stallreq && perf_lu_cnt != 32'hFFFF_FFFF)
      perf_lu_cnt <= perf_lu_cnt + 32'd1;
  end
`endif

endmodule
